// File: rtl/accel_spi_responder.sv
// rtl/accel_spi_responder.sv - SPI mode-0 slave emulating the accelerometer register interface
module accel_spi_responder #(
   parameter int CLK_PER_HALF_SCLK_MIN = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        SCLK,
   input  logic        CS,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [15:0] y_sample,
   input  logic [15:0] z_sample,
   output logic        measure_en,
   output logic        wr_strobe,
   output logic [5:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        cmd_error,
   output logic        xfer_done
);

   if (CLK_PER_HALF_SCLK_MIN < 4) begin : g_half_check
      $error("CLK_PER_HALF_SCLK_MIN must be at least 4");
   end

   localparam logic [7:0] CMD_WRITE = 8'h0A;
   localparam logic [7:0] CMD_READ  = 8'h0B;

   typedef enum logic [2:0] {WAIT_IDLE, IDLE, CMD, ADDR, RDATA, WDATA, IGNORE} state_t;
   state_t state, state_next;

   // [0] first sync flop, [1] synchronized value, [2] history for edge detection
   logic [2:0] sclk_sy, cs_sy;
   logic [1:0] mosi_sy;
   logic       sclk_rise, sclk_fall, cs_rise, cs_fall, byte_done;
   logic [2:0] bit_cnt;
   logic [6:0] rx_sr;
   logic [7:0] rx_byte, tx_sr, rd_data;
   logic       tx_out, miso_q, is_read, soft_pend, ram_hit;
   logic [5:0] addr, rd_addr;
   logic [15:0] y_shadow, z_shadow;
   logic [7:0] ram [0:15];
   logic       cmd_done, addr_done, rd_next, commit, cmd_err_set, done_set;

   assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
   assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];
   assign cs_rise   = cs_sy[1] & ~cs_sy[2];
   assign cs_fall   = ~cs_sy[1] & cs_sy[2];
   assign rx_byte   = {rx_sr, mosi_sy[1]};
   assign byte_done = sclk_rise && (bit_cnt == 3'd7);
   assign ram_hit   = (addr[5:4] == 2'b10) && (addr[3:0] != 4'hF);
   assign MISO      = miso_q & ~CS;

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sy <= '0;
         cs_sy   <= '0;
         mosi_sy <= '0;
         state   <= WAIT_IDLE;
      end else begin
         sclk_sy <= {sclk_sy[1:0], SCLK};
         cs_sy   <= {cs_sy[1:0], CS};
         mosi_sy <= {mosi_sy[0], MOSI};
         state   <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      cmd_done    = 1'b0;
      addr_done   = 1'b0;
      rd_next     = 1'b0;
      commit      = 1'b0;
      cmd_err_set = 1'b0;
      done_set    = 1'b0;
      if (state == WAIT_IDLE) begin
         if (cs_sy[1]) state_next = IDLE;
      end else if (cs_rise) begin
         state_next = IDLE;
         done_set   = 1'b1;
      end else begin
         case (state)
            IDLE: if (cs_fall) state_next = CMD;
            CMD: if (byte_done) begin
               if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                  state_next = ADDR;
                  cmd_done   = 1'b1;
               end else begin
                  state_next  = IGNORE;
                  cmd_err_set = 1'b1;
               end
            end
            ADDR: if (byte_done) begin
               addr_done  = 1'b1;
               state_next = is_read ? RDATA : WDATA;
            end
            RDATA:   rd_next = byte_done;
            WDATA:   commit  = byte_done;
            default: ;
         endcase
      end
   end

   // The address byte itself selects the first read; later reads prefetch addr+1
   always_comb begin
      rd_addr = (state == ADDR) ? rx_byte[5:0] : addr + 6'd1;
      rd_data = 8'h00;
      case (rd_addr)
         6'h00:   rd_data = 8'hAD;
         6'h01:   rd_data = 8'h1D;
         6'h02:   rd_data = 8'hF2;
         6'h10:   rd_data = y_shadow[7:0];
         6'h11:   rd_data = y_shadow[15:8];
         6'h12:   rd_data = z_shadow[7:0];
         6'h13:   rd_data = z_shadow[15:8];
         default: if (rd_addr[5:4] == 2'b10 && rd_addr[3:0] != 4'hF) rd_data = ram[rd_addr[3:0]];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt    <= '0;
         rx_sr      <= '0;
         tx_sr      <= '0;
         tx_out     <= 1'b0;
         miso_q     <= 1'b0;
         addr       <= '0;
         is_read    <= 1'b0;
         y_shadow   <= '0;
         z_shadow   <= '0;
         soft_pend  <= 1'b0;
         measure_en <= 1'b0;
         wr_strobe  <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         cmd_error  <= 1'b0;
         xfer_done  <= 1'b0;
         for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      end else begin
         wr_strobe  <= 1'b0;
         cmd_error  <= cmd_err_set;
         xfer_done  <= done_set;
         soft_pend  <= 1'b0;
         miso_q     <= tx_out;
         measure_en <= (ram[13][1:0] == 2'b10);
         if (soft_pend) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
         end
         if (cs_fall) begin
            y_shadow <= y_sample;
            z_shadow <= z_sample;
            bit_cnt  <= '0;
         end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sr   <= rx_byte[6:0];
         end
         if (state != RDATA) tx_out <= 1'b0;
         else if (sclk_fall) tx_out <= tx_sr[7];
         if (cmd_done) is_read <= (rx_byte == CMD_READ);
         if (addr_done) begin
            addr  <= rx_byte[5:0];
            tx_sr <= rd_data;
         end else if (rd_next) begin
            addr  <= addr + 6'd1;
            tx_sr <= rd_data;
         end else if (commit) begin
            addr <= addr + 6'd1;
            if (ram_hit || addr == 6'h1F) begin
               wr_strobe <= 1'b1;
               wr_addr   <= addr;
               wr_data   <= rx_byte;
            end
            if (ram_hit) ram[addr[3:0]] <= rx_byte;
            if (addr == 6'h1F && rx_byte == 8'h52) soft_pend <= 1'b1;
         end else if (state == RDATA && sclk_fall) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_accel_spi_responder.sv
// tb/tb_accel_spi_responder.sv - randomized self-checking bench for accel_spi_responder
module tb_accel_spi_responder;
   localparam int HALF = 6;

   logic        clk, reset, SCLK, CS, MOSI, MISO;
   logic [15:0] y_sample, z_sample;
   logic        measure_en, wr_strobe, cmd_error, xfer_done;
   logic [5:0]  wr_addr;
   logic [7:0]  wr_data;

   accel_spi_responder #(.CLK_PER_HALF_SCLK_MIN(4)) dut (
      .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
      .y_sample(y_sample), .z_sample(z_sample), .measure_en(measure_en),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
      .cmd_error(cmd_error), .xfer_done(xfer_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: register contents as a flat 64-entry map
   logic [7:0]  ram_m [0:63];
   logic [15:0] y_snap, z_snap;
   logic [7:0]  wq[$];
   logic [13:0] st_q[$];
   logic [13:0] exp_q[$];
   int n_done = 0;
   int n_err  = 0;

   function automatic bit writable(input logic [5:0] a);
      return (a >= 6'h20) && (a <= 6'h2E);
   endfunction

   function automatic logic [7:0] model_read(input logic [5:0] a);
      case (a)
         6'h00:   return 8'hAD;
         6'h01:   return 8'h1D;
         6'h02:   return 8'hF2;
         6'h10:   return y_snap[7:0];
         6'h11:   return y_snap[15:8];
         6'h12:   return z_snap[7:0];
         6'h13:   return z_snap[15:8];
         default: return writable(a) ? ram_m[a] : 8'h00;
      endcase
   endfunction

   always @(negedge clk) begin
      if (wr_strobe) st_q.push_back({wr_addr, wr_data});
      if (xfer_done) n_done++;
      if (cmd_error) n_err++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         MOSI = tx[7-i];
         wait_clk(HALF);
         rx = {rx[6:0], MISO};
         SCLK = 1'b1;
         wait_clk(HALF);
         SCLK = 1'b0;
      end
   endtask

   task automatic cs_start();
      y_snap = y_sample;
      z_snap = z_sample;
      CS = 1'b0;
      wait_clk(2 * HALF);
   endtask

   task automatic cs_end();
      wait_clk(HALF);
      CS   = 1'b1;
      MOSI = 1'b0;
      wait_clk(3 * HALF);
   endtask

   task automatic read_burst(input logic [7:0] a, input int n, input bit chg, input string tag);
      logic [7:0] rx;
      logic [5:0] p;
      int d0;
      d0 = n_done;
      p  = a[5:0];
      cs_start();
      spi_bits(8'h0B, 8, rx);
      spi_bits(a, 8, rx);
      for (int i = 0; i < n; i++) begin
         spi_bits(8'h00, 8, rx);
         check($sformatf("%s_rd[%0d]@%0h", tag, i, p), rx, model_read(p));
         p = p + 6'd1;
         if (chg && i == 0) begin
            y_sample = y_sample ^ 16'hFFFF;
            z_sample = z_sample + 16'h1111;
         end
      end
      cs_end();
      check({tag, "_xfer_done"}, n_done - d0, 1);
   endtask

   task automatic write_burst(input logic [7:0] a, input string tag);
      logic [7:0] rx;
      logic [5:0] p;
      int d0;
      d0 = n_done;
      p  = a[5:0];
      st_q.delete();
      exp_q.delete();
      cs_start();
      spi_bits(8'h0A, 8, rx);
      spi_bits(a, 8, rx);
      foreach (wq[i]) begin
         spi_bits(wq[i], 8, rx);
         if (writable(p) || p == 6'h1F) exp_q.push_back({p, wq[i]});
         if (writable(p)) ram_m[p] = wq[i];
         if (p == 6'h1F && wq[i] == 8'h52) begin
            for (int k = 0; k < 64; k++) ram_m[k] = 8'h00;
         end
         p = p + 6'd1;
      end
      cs_end();
      check({tag, "_nstrobe"}, st_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < st_q.size(); i++)
         check($sformatf("%s_strobe[%0d]", tag, i), st_q[i], exp_q[i]);
      check({tag, "_measure_en"}, measure_en, ram_m[6'h2D][1:0] == 2'b10);
      check({tag, "_xfer_done"}, n_done - d0, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rx;
      logic [7:0] a;
      int e0;
      for (int k = 0; k < 64; k++) ram_m[k] = 8'h00;
      reset = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      y_sample = 16'h1234; z_sample = 16'hABCD;
      wait_clk(4);
      reset = 1'b0;
      wait_clk(1);
      check("rst_miso", MISO, 0);
      check("rst_measure_en", measure_en, 0);
      check("rst_wr_strobe", wr_strobe, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_cmd_error", cmd_error, 0);
      check("rst_xfer_done", xfer_done, 0);
      wait_clk(6);

      read_burst(8'h00, 3, 1'b0, "id");

      wq.delete(); wq.push_back(8'h02);
      write_burst(8'h2D, "pwr");
      check("pwr_measure_on", measure_en, 1);
      read_burst(8'h2D, 1, 1'b0, "pwr_rb");

      y_sample = 16'h1234; z_sample = 16'hABCD;
      read_burst(8'h10, 4, 1'b1, "axis");

      wq.delete(); wq.push_back(8'h52);
      write_burst(8'h1F, "soft");
      check("soft_measure_off", measure_en, 0);
      read_burst(8'h2D, 1, 1'b0, "soft_rb");

      st_q.delete();
      e0 = n_err;
      cs_start();
      spi_bits(8'h0C, 8, rx);
      spi_bits(8'h20, 8, rx);
      check("err_miso0", rx, 0);
      spi_bits(8'hFF, 8, rx);
      check("err_miso1", rx, 0);
      cs_end();
      check("err_pulse", n_err - e0, 1);
      check("err_nstrobe", st_q.size(), 0);

      wq.delete(); wq.push_back(8'h3C);
      write_burst(8'h20, "pre_abort");
      st_q.delete();
      cs_start();
      spi_bits(8'h0A, 8, rx);
      spi_bits(8'h20, 8, rx);
      spi_bits(8'hC3, 5, rx);
      cs_end();
      check("abort_nstrobe", st_q.size(), 0);
      read_burst(8'h20, 1, 1'b0, "abort_rb");

      wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
      write_burst(8'h3F, "wrap");
      read_burst(8'h00, 1, 1'b0, "wrap_rb");

      for (int it = 0; it < 24; it++) begin
         y_sample = 16'($urandom);
         z_sample = 16'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {2'($urandom), 6'h20 + 6'($urandom_range(0, 14))};
            if (a[5:0] == 6'h1F) a = 8'h21;
            wq.delete();
            for (int j = $urandom_range(1, 3); j > 0; j--) wq.push_back(8'($urandom));
            write_burst(a, $sformatf("rw%0d", it));
         end else begin
            case ($urandom_range(0, 2))
               0:       a = {2'($urandom), 6'h10 + 6'($urandom_range(0, 3))};
               1:       a = {2'($urandom), 6'h1E + 6'($urandom_range(0, 16))};
               default: a = 8'($urandom);
            endcase
            read_burst(a, $urandom_range(1, 4), 1'b0, $sformatf("rr%0d", it));
         end
      end

      wq.delete(); wq.push_back(8'h5A);
      write_burst(8'h21, "pre_rst");
      st_q.delete();
      cs_start();
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'h21, 8, rx);
      spi_bits(8'h00, 4, rx);
      reset = 1'b1;
      wait_clk(2);
      reset = 1'b0;
      for (int k = 0; k < 64; k++) ram_m[k] = 8'h00;
      spi_bits(8'h00, 8, rx);
      check("rst_silent_miso", rx, 0);
      spi_bits(8'h0A, 8, rx);
      spi_bits(8'h22, 8, rx);
      spi_bits(8'h77, 8, rx);
      check("rst_silent_miso2", rx, 0);
      cs_end();
      check("rst_silent_nstrobe", st_q.size(), 0);
      read_burst(8'h21, 2, 1'b0, "post_rst");
      wq.delete(); wq.push_back(8'h02);
      write_burst(8'h2D, "post_rst_w");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
